lfsr_hex_gen: RTL
=================

Name: lfsr_hex_gen

Overview:
Parametrised Fibonacci LFSR pseudo-random generator with an on-board hex display driver, for NVBoard lab exercises.
- Adds a configurable width and tap polynomial.
- Adds run/hold control, runtime seed load with a lock-up guard, and measurement of the sequence period.
- The current state drives WIDTH/4 active-low seven-segment digits directly.

Parameters:
WIDTH, 8, LFSR width in bits; multiple of 4, range 4..32.
TAPS, 8'h1D, feedback tap mask (bit i set means state[i] feeds the XOR); TAPS[0] must be 1; WIDTH bits wide.
SEED, 1, reset seed; must be nonzero; WIDTH bits wide.
NDIG, WIDTH/4, number of hex digits (derived; not overridable).

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
en  in  1  advance the LFSR one step per cycle while high
load  in  1  one-cycle strobe; load seed_in
seed_in  in  WIDTH  seed value for load
state  out  WIDTH  current LFSR state
hex  out  7*NDIG  segments; digit k at [7k+6:7k] shows nibble state[4k+3:4k]; segment order {g,f,e,d,c,b,a}; active-low
wrap  out  1  one-cycle pulse when the sequence returns to the active seed
period  out  WIDTH  step count of the last completed cycle
period_valid  out  1  high once period holds a measured value

Behaviour:
- Priority each cycle: reset > load > en > hold.
- Reset:
  - state=SEED, active seed register=SEED, step counter=0.
  - wrap=0, period=0, period_valid=0.
  - hex shows the decode of SEED one cycle after reset is released. hex is combinational from state.
- Step (en=1, load=0):
  - fb = XOR of state[i] over all i with TAPS[i]=1.
  - state <= {fb, state[WIDTH-1:1]}: shift right, new bit enters the MSB.
  - One step per enabled cycle; no other latency.
- Load (load=1):
  - state <= seed_in, and the active seed register <= seed_in, in the same cycle.
  - If seed_in==0, the value 1 is loaded instead (zero lock-up guard).
  - Step counter is cleared; period and period_valid are cleared.
  - en is ignored in that cycle.
- Hold (en=0, load=0): all registers keep their values; wrap=0.
- Period measurement:
  - The step counter (WIDTH bits) increments on every step.
  - On a step whose next state equals the active seed:
    - wrap=1 for exactly that following cycle.
    - period <= counter+1; period_valid <= 1; counter <= 0.
  - The maximum period 2^WIDTH-1 fits in WIDTH bits. The counter saturates at all-ones as a guard; with TAPS[0]=1 this is unreachable.
- Hex decode:
  - Active-low patterns, digits 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, {g..a}).
- Reset asserted mid-run overrides everything in that cycle. There is no partial state.
- state never becomes 0 under any legal stimulus.

Decomposition:
- Shared package lfsr_pkg holds:
  - the seven-segment lookup constant (16 x 7 bits, active-low);
  - a function that computes the feedback parity from state and mask;
  - the default TAPS constants for widths 4, 8, 16 and 32 (4'h3, 8'h1D, 16'h002D, 32'h000000C5 in this shift-right form; reviewed against maximal-length tables by DV).
- One sub-module, hex7seg: a 4-bit nibble to 7-bit active-low decoder, instantiated NDIG times in a generate loop.

Test Plan:
- Reset, WIDTH=8 defaults -> state=0x01; hex[6:0]=0x79, hex[13:7]=0x40; period_valid=0; wrap=0.
- en=1 for 5 cycles from 0x01 -> state sequence 0x80, 0x40, 0x20, 0x10, 0x88.
- en=1 held for 255 cycles from reset -> wrap pulses once on cycle 255 with state=0x01; period=255; period_valid=1; the next wrap comes 255 cycles later.
- load=1 with seed_in=0x00 and en=1 in the same cycle -> state=0x01, counter=0, no step, period_valid=0.
- load seed_in=0xA5, then toggle en -> state holds while en=0; hex shows digit A (0x08) and digit 5 (0x12); wrap occurs when state returns to 0xA5 after 255 steps.
- reset asserted mid-run at step 100 -> the next cycle has state=0x01, period=0, period_valid=0, wrap=0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the LFSR hex generator.
package lfsr_pkg;

    // Widest LFSR supported; parity helper works on this many bits.
    localparam int unsigned MAX_WIDTH = 32;

    // Active-low seven-segment patterns {g,f,e,d,c,b,a}, indexed by nibble value.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46,  // F E D C
        7'h03, 7'h08, 7'h10, 7'h00,  // B A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,  // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40   // 3 2 1 0
    };

    // Default tap masks for the shift-right Fibonacci form.
    localparam logic [3:0]  TAPS_W4  = 4'h3;
    localparam logic [7:0]  TAPS_W8  = 8'h1D;
    localparam logic [15:0] TAPS_W16 = 16'h002D;
    localparam logic [31:0] TAPS_W32 = 32'h000000C5;

    // XOR of every state bit selected by the tap mask.
    function automatic logic lfsr_parity(input logic [MAX_WIDTH-1:0] s,
                                         input logic [MAX_WIDTH-1:0] mask);
        return ^(s & mask);
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Nibble to active-low seven-segment decoder.
module hex7seg
    import lfsr_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup; segment order {g,f,e,d,c,b,a}.
    always_comb begin
        seg = SEG_LUT[nibble];
    end

endmodule

// File: rtl/lfsr_hex_gen.sv
// Fibonacci LFSR with run/hold, seed load, period measurement and hex display.
module lfsr_hex_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_W8,
    parameter logic [WIDTH-1:0] SEED  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    load,
    input  logic [WIDTH-1:0]        seed_in,
    output logic [WIDTH-1:0]        state,
    output logic [7*(WIDTH/4)-1:0]  hex,
    output logic                    wrap,
    output logic [WIDTH-1:0]        period,
    output logic                    period_valid
);

    localparam int unsigned NDIG = WIDTH / 4;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;

    logic             fb;
    logic [WIDTH-1:0] step_state;
    logic [WIDTH-1:0] load_seed;

    // Feedback bit and the shifted-right successor state.
    always_comb begin
        fb         = lfsr_parity(MAX_WIDTH'(state_q), MAX_WIDTH'(TAPS));
        step_state = {fb, state_q[WIDTH-1:1]};
        // All-zero seed would lock the register up, so substitute 1.
        load_seed  = (seed_in == '0) ? ONE : seed_in;
    end

    // Next-state: load beats step beats hold; reset handled in the register.
    always_comb begin
        state_d  = state_q;
        seed_d   = seed_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = valid_q;
        wrap_d   = 1'b0;
        if (load) begin
            state_d  = load_seed;
            seed_d   = load_seed;
            cnt_d    = '0;
            period_d = '0;
            valid_d  = 1'b0;
        end else if (en) begin
            state_d = step_state;
            if (step_state == seed_q) begin
                wrap_d   = 1'b1;
                period_d = (cnt_q == ALL_ONES) ? ALL_ONES : cnt_q + ONE;
                valid_d  = 1'b1;
                cnt_d    = '0;
            end else begin
                // Saturating guard; unreachable with a maximal tap set.
                cnt_d = (cnt_q == ALL_ONES) ? ALL_ONES : cnt_q + ONE;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SEED;
            seed_q   <= SEED;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            seed_q   <= seed_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
        end
    end

    // Drive outputs straight from the registers.
    always_comb begin
        state        = state_q;
        wrap         = wrap_q;
        period       = period_q;
        period_valid = valid_q;
    end

    // One decoder per nibble of the current state.
    for (genvar k = 0; k < NDIG; k++) begin : g_digit
        hex7seg u_hex7seg (
            .nibble (state_q[4*k +: 4]),
            .seg    (hex[7*k +: 7])
        );
    end

endmodule
